// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, HALT detection and jorb flush.
// Optional IF_ID_PERF_COUNT_EN adds saturating stall/flush event counters.
module if_id_stage #(
   parameter logic [4:0]  LD_OPCODE       = 5'b10001,
   parameter logic [4:0]  HALT_OPCODE     = 5'b00000,
   parameter logic [15:0] NOP_INSTR       = 16'h0800,
   parameter int unsigned LD_STALL_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] if_instr,
   input  logic [15:0] if_PC,
   input  logic [15:0] if_PCPlus1,
   input  logic        jorb,
   output logic [15:0] id_instr,
   output logic [15:0] id_PC,
   output logic [15:0] id_PCPlus1,
   output logic        id_valid,
   output logic        ldStall,
   output logic [15:0] ldStallPC,
   output logic        halt,
`ifdef IF_ID_PERF_COUNT_EN
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt,
`endif
   output logic [15:0] haltPC
);

   typedef enum logic [1:0] {RUN, STALL, HALTED} state_e;

   localparam logic [1:0] STALL_INIT = 2'(LD_STALL_CYCLES - 1);

   state_e      state_q, state_d;
   logic [15:0] id_instr_q, id_instr_d;
   logic [15:0] id_pc_q, id_pc_d;
   logic [15:0] id_pcp1_q, id_pcp1_d;
   logic        id_valid_q, id_valid_d;
   logic        halt_q, halt_d;
   logic [15:0] halt_pc_q, halt_pc_d;
   logic [1:0]  cnt_q, cnt_d;

   logic [4:0]  id_opc;
   logic [2:0]  ld_dest;
   logic        hz;
   logic        halt_det;

   always_comb begin
      id_opc   = id_instr_q[15:11];
      ld_dest  = id_instr_q[7:5];
      hz       = id_valid_q && (id_opc == LD_OPCODE) &&
                 ((if_instr[10:8] == ld_dest) || (if_instr[7:5] == ld_dest)) &&
                 (state_q == RUN) && !jorb;
      halt_det = id_valid_q && (id_opc == HALT_OPCODE) && (state_q == RUN) && !jorb;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (jorb)                            state_d = RUN;
            else if (halt_det)                   state_d = HALTED;
            else if (hz && (STALL_INIT != '0))   state_d = STALL;
         end
         STALL: begin
            if (jorb || (cnt_q <= 2'd1))         state_d = RUN;
         end
         HALTED:                                 state_d = HALTED;
         default:                                state_d = RUN;
      endcase
   end

   // Every non-latch path inserts a bubble; PCs hold so a bubble keeps the last real PC.
   always_comb begin
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
      id_pc_d    = id_pc_q;
      id_pcp1_d  = id_pcp1_q;
      halt_d     = halt_q;
      halt_pc_d  = halt_pc_q;
      cnt_d      = cnt_q;
      case (state_q)
         RUN: begin
            if (jorb) begin
               cnt_d = '0;
            end else if (halt_det) begin
               halt_d    = 1'b1;
               halt_pc_d = id_pc_q;
            end else if (hz) begin
               cnt_d = STALL_INIT;
            end else begin
               id_instr_d = if_instr;
               id_valid_d = 1'b1;
               id_pc_d    = if_PC;
               id_pcp1_d  = if_PCPlus1;
            end
         end
         STALL: begin
            if (jorb)               cnt_d = '0;
            else if (cnt_q != '0)   cnt_d = cnt_q - 2'd1;
         end
         default: cnt_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         id_instr_q <= NOP_INSTR;
         id_valid_q <= 1'b0;
         id_pc_q    <= '0;
         id_pcp1_q  <= '0;
         halt_q     <= 1'b0;
         halt_pc_q  <= '0;
         cnt_q      <= '0;
      end else begin
         id_instr_q <= id_instr_d;
         id_valid_q <= id_valid_d;
         id_pc_q    <= id_pc_d;
         id_pcp1_q  <= id_pcp1_d;
         halt_q     <= halt_d;
         halt_pc_q  <= halt_pc_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      ldStall   = hz || ((state_q == STALL) && (cnt_q != '0) && !jorb);
      ldStallPC = if_PC;
   end

   assign id_instr   = id_instr_q;
   assign id_PC      = id_pc_q;
   assign id_PCPlus1 = id_pcp1_q;
   assign id_valid   = id_valid_q;
   assign halt       = halt_q;
   assign haltPC     = halt_pc_q;

`ifdef IF_ID_PERF_COUNT_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (ldStall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 16'd1;
         if (jorb && (state_q != HALTED) && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Pipeline register and hazard control between fetch and decode.
- Captures the fetch stage's instr, PC and PCPlus1 into ID-stage registers.
- Detects load-use hazards and drives ldStall/ldStallPC back to fetch.
- Detects HALT and drives halt/haltPC to fetch; squashes the latched instruction when a later stage asserts jorb.

Parameters:
- LD_OPCODE, 5'b10001, opcode in instr[15:11] identifying a load.
- HALT_OPCODE, 5'b00000, opcode identifying HALT.
- NOP_INSTR, 16'h0800, encoding driven on id_instr for a bubble.
- LD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; range 1..3.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk).
- if_instr  in  16  instruction from fetch memory (combinational read of current PC).
- if_PC  in  16  fetch PC.
- if_PCPlus1  in  16  fetch PC+1.
- jorb  in  1  taken jump/branch resolved downstream; flush request.
- id_instr  out  16  latched instruction, or NOP_INSTR when bubble.
- id_PC  out  16  latched PC.
- id_PCPlus1  out  16  latched PC+1.
- id_valid  out  1  1 = id_instr is a real instruction.
- ldStall  out  1  combinational; fetch holds PC this cycle.
- ldStallPC  out  16  PC fetch must hold (= if_PC).
- halt  out  1  sticky halt to fetch.
- haltPC  out  16  PC fetch parks on while halted.

Behaviour:
- Reset (rst=0 at edge):
  - id_instr=NOP_INSTR, id_PC=0, id_PCPlus1=0, id_valid=0.
  - halt=0, haltPC=0, stall counter=0, pending dest=0, FSM=RUN.
- Field decode on if_instr: opc=[15:11], rs=[10:8], rt=[7:5]. A load's destination is id_instr[7:5].
- Hazard:
  - hz = id_valid & (id_instr opc==LD_OPCODE) & (rs==dest | rt==dest) & FSM==RUN & !jorb.
  - ldStall = hz | (stall counter != 0).
  - ldStallPC = if_PC.
- FSM has three states: RUN, STALL, HALTED.
- RUN:
  - If jorb: latch bubble (id_valid=0, id_instr=NOP_INSTR, id_PC/id_PCPlus1 hold).
  - Else if hz: latch bubble; counter <= LD_STALL_CYCLES-1; go STALL if counter would be nonzero.
  - Else latch if_* with id_valid=1.
- STALL:
  - ldStall=1; latch bubble; counter decrements each cycle.
  - Return to RUN when counter reaches 0. The next cycle latches the held instruction normally.
  - jorb in STALL: counter cleared, bubble latched, next state RUN, ldStall deasserted that same cycle.
- HALT detect:
  - When id_valid=1 and id_instr opc==HALT_OPCODE: set halt=1 and haltPC=id_PC on that edge, then enter HALTED.
  - halt is registered, so fetch sees it one cycle after HALT is in ID.
  - If jorb is asserted in the same cycle, jorb wins: HALT is squashed and no halt occurs.
- HALTED:
  - halt=1 and haltPC held until reset; bubbles latched every cycle.
  - ldStall=0; jorb ignored.
- Priority per edge: reset > HALTED > jorb > stall/hazard > normal latch.
- Width rules:
  - All PCs are 16-bit, no arithmetic performed here.
  - The counter is 2-bit and never underflows: decrement only while nonzero.
- Reset mid-stall or mid-halt returns every state to the reset values above on the next edge.

Optional Feature:
- Macro: IF_ID_PERF_COUNT_EN.
- When defined, adds two outputs:
  - stall_cnt (16, out): increments on every edge where ldStall=1.
  - flush_cnt (16, out): increments on every edge where jorb=1 and FSM!=HALTED.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, neither the ports nor the logic exist, and all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles with if_instr=16'hFFFF -> id_valid=0, id_instr=NOP_INSTR, halt=0, ldStall=0.
- Straight-line: PCs 0,1,2 with non-load instrs -> id_PC lags if_PC by exactly one cycle, id_valid=1, ldStall never asserts.
- Load-use: ID holds LD dest=R3 (id_instr=16'h8860), if_instr reads R3 as rs (16'h4300 at PC=5) -> ldStall=1 and ldStallPC=5 for 1 cycle; one bubble; next cycle id_instr=16'h4300, id_PC=5. With LD_STALL_CYCLES=3: ldStall high 3 cycles, 3 bubbles.
- Flush during stall: assert jorb in the 2nd stall cycle (LD_STALL_CYCLES=3) -> bubble latched, ldStall=0 same cycle, FSM RUN, stall ends early.
- Halt: HALT at PC=12 reaches ID -> next cycle halt=1, haltPC=12; remains so for 20 cycles with jorb toggling; rst=0 clears halt.
- Perf (IF_ID_PERF_COUNT_EN): 2 hazards at LD_STALL_CYCLES=2 plus 3 jorb pulses -> stall_cnt=4, flush_cnt=3.
